// File: rtl/sts_fault_pkg.sv
// Shared constants for the status fault latch: group indices, vector geometry,
// FIFO entry layout and the lowest-set-bit encoder used by the top.
package sts_fault_pkg;

    localparam int GRP_DAC_OVER_THRESH      = 0;
    localparam int GRP_ADC_OVER_THRESH      = 1;
    localparam int GRP_DAC_THRESH_UNDERFLOW = 2;
    localparam int GRP_DAC_THRESH_OVERFLOW  = 3;
    localparam int GRP_ADC_THRESH_UNDERFLOW = 4;
    localparam int GRP_ADC_THRESH_OVERFLOW  = 5;
    localparam int GRP_DAC_BUF_UNDERFLOW    = 6;
    localparam int GRP_ADC_BUF_OVERFLOW     = 7;
    localparam int GRP_PREMAT_DAC_TRIG      = 8;
    localparam int GRP_PREMAT_ADC_TRIG      = 9;
    localparam int GRP_PREMAT_DAC_DIV       = 10;
    localparam int GRP_PREMAT_ADC_DIV       = 11;

    localparam int NUM_GROUPS   = 12;
    localparam int CH_PER_GROUP = 8;
    localparam int FAULT_BITS   = NUM_GROUPS * CH_PER_GROUP;

    localparam int ENTRY_TS_LSB  = 7;
    localparam int ENTRY_GRP_LSB = 3;
    localparam int ENTRY_CH_LSB  = 0;
    localparam int CODE_W        = 7;

    // Returns the lowest set index, or 0 when the vector is empty.
    function automatic logic [CODE_W-1:0] lowest_set(input logic [FAULT_BITS-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = FAULT_BITS - 1; i >= 0; i--) begin
            if (v[i]) idx = CODE_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sts_event_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Storage is not reset; the head output is forced to zero while empty.
module sts_event_fifo #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              do_rd, do_wr;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;
    assign do_rd   = rd_en & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a write.
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (ADDR_W + 1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/sts_fault_latch.sv
// Sticky fault latch: rising-edge detect on the synchronized status vector,
// first-fault capture, timestamped event serializer into a FIFO, level irq.
module sts_fault_latch
    import sts_fault_pkg::*;
#(
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int TS_WIDTH        = 25
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       spi_running_stable,
    input  logic [95:0]                fault_vec,
    input  logic                       irq_en,
    input  logic                       clr_sticky,
    input  logic                       rd_en,
    output logic [95:0]                sticky,
    output logic                       first_fault_valid,
    output logic [6:0]                 first_fault_code,
    output logic                       irq,
    output logic [31:0]                fifo_rd_data,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_count,
    output logic                       fifo_overflow
);
    logic [FAULT_BITS-1:0] prev_vec, pending, sticky_q, rise, push_mask;
    logic [TS_WIDTH-1:0]   ts;
    logic                  spi_prev;
    logic                  ffv_q, ovf_q, irq_q;
    logic [CODE_W-1:0]     ffc_q, push_idx, rise_idx;
    logic                  push, drop;
    logic [TS_WIDTH+CODE_W-1:0] entry;

    assign rise      = fault_vec & ~prev_vec;
    assign rise_idx  = lowest_set(rise);
    assign push      = |pending;
    assign push_idx  = lowest_set(pending);
    assign push_mask = push ? (FAULT_BITS'(1) << push_idx) : '0;
    assign entry     = {ts, push_idx};
    // The FIFO makes room on a simultaneous pop, so only a pop-less push into a full FIFO is lost.
    assign drop      = push & fifo_full & ~rd_en;

    sts_event_fifo #(
        .ADDR_W (FIFO_ADDR_WIDTH),
        .DATA_W (TS_WIDTH + CODE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (entry),
        .rd_en   (rd_en),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_vec <= '0;
            pending  <= '0;
            sticky_q <= '0;
            ffv_q    <= 1'b0;
            ffc_q    <= '0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            ts       <= '0;
            spi_prev <= 1'b0;
        end else begin
            prev_vec <= fault_vec;
            spi_prev <= spi_running_stable;
            // New rises OR in after the serviced bit is cleared, so a same-cycle rise re-arms it.
            pending  <= (pending & ~push_mask) | rise;
            sticky_q <= (clr_sticky ? '0 : sticky_q) | rise;
            if (clr_sticky) begin
                ffv_q <= |rise;
                ffc_q <= rise_idx;
            end else if (!ffv_q && |rise) begin
                ffv_q <= 1'b1;
                ffc_q <= rise_idx;
            end
            ovf_q <= drop | (ovf_q & ~clr_sticky);
            irq_q <= irq_en & (|sticky_q | ovf_q);
            ts    <= (spi_running_stable & ~spi_prev) ? '0 : ts + TS_WIDTH'(1);
        end
    end

    assign sticky            = sticky_q;
    assign first_fault_valid = ffv_q;
    assign first_fault_code  = ffc_q;
    assign fifo_overflow     = ovf_q;
    assign irq               = irq_q;

endmodule
